// File: rtl/frame_buf_pkg.sv
// Shared DDR frame-buffer map and read-side state encoding.
// The frame writer and the frame reader both import this package.
package frame_buf_pkg;

    localparam int unsigned DDR_BASE   = 32'd62914560;
    localparam int unsigned PKG_WORDS  = 32'd1024;
    localparam int unsigned PKG_STRIDE = 32'd4096;
    localparam int unsigned PKG_NUM    = 32'd2048;
    localparam int unsigned LINE_W     = 32'd2048;
    localparam int unsigned POS_W      = 32'd11;
    localparam int unsigned PIX_W      = 32'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } rd_state_e;

    // Byte address of a package; the sum wraps modulo 2^32.
    function automatic logic [31:0] pkg_addr(input logic [31:0] base,
                                             input logic [31:0] idx,
                                             input logic [31:0] stride);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/ddr_frame_reader_if.sv
// FDMA read-package port: package request out, data strobes back.
interface ddr_frame_reader_if;

    logic [31:0] pkg_rd_addr;
    logic [31:0] pkg_rd_size;
    logic        pkg_rd_areq;
    logic        pkg_rd_en;
    logic [31:0] pkg_rd_data;
    logic        pkg_rd_last;

    modport master (
        output pkg_rd_addr,
        output pkg_rd_size,
        output pkg_rd_areq,
        input  pkg_rd_en,
        input  pkg_rd_data,
        input  pkg_rd_last
    );

    modport slave (
        input  pkg_rd_addr,
        input  pkg_rd_size,
        input  pkg_rd_areq,
        output pkg_rd_en,
        output pkg_rd_data,
        output pkg_rd_last
    );

endinterface

// File: rtl/ddr_frame_reader_pix_pos_cnt.sv
// Next-pixel coordinate counter: x wraps at LINE_W-1 and carries into y.
module pix_pos_cnt #(
    parameter int unsigned LINE_W = frame_buf_pkg::LINE_W,
    parameter int unsigned POS_W  = frame_buf_pkg::POS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y
);

    localparam logic [POS_W-1:0] X_LAST = POS_W'(LINE_W - 32'd1);

    // Coordinate register: clear wins over advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x <= {POS_W{1'b0}};
            pos_y <= {POS_W{1'b0}};
        end else if (clr) begin
            pos_x <= {POS_W{1'b0}};
            pos_y <= {POS_W{1'b0}};
        end else if (en) begin
            if (pos_x == X_LAST) begin
                pos_x <= {POS_W{1'b0}};
                pos_y <= pos_y + POS_W'(1);
            end else begin
                pos_x <= pos_x + POS_W'(1);
            end
        end
    end

endmodule

// File: rtl/ddr_frame_reader.sv
// Replays one stored frame from DDR as a 12-bit pixel stream, one package
// request at a time, with frame/data valid and pixel coordinates.
module ddr_frame_reader #(
    parameter int unsigned DDR_BASE   = frame_buf_pkg::DDR_BASE,
    parameter int unsigned PKG_WORDS  = frame_buf_pkg::PKG_WORDS,
    parameter int unsigned PKG_STRIDE = frame_buf_pkg::PKG_STRIDE,
    parameter int unsigned PKG_NUM    = frame_buf_pkg::PKG_NUM,
    parameter int unsigned LINE_W     = frame_buf_pkg::LINE_W
) (
    input  logic                       clk_100m,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       len_err,
    ddr_frame_reader_if.master         pkg_rd,
    output logic [11:0]                img,
    output logic                       data_valid,
    output logic                       frame_valid,
    output logic [10:0]                pos_x,
    output logic [10:0]                pos_y
);

    localparam logic [31:0] BASE_ADDR  = 32'(DDR_BASE);
    localparam logic [31:0] STRIDE     = 32'(PKG_STRIDE);
    localparam logic [31:0] WORDS_LAST = 32'(PKG_WORDS - 32'd1);
    localparam logic [31:0] PKG_LAST   = 32'(PKG_NUM - 32'd1);

    frame_buf_pkg::rd_state_e state_r;

    logic [31:0] pkg_cnt_r;
    logic [31:0] word_cnt_r;
    logic [31:0] addr_r;
    logic        areq_r;
    logic        busy_r;
    logic        done_r;
    logic        len_err_r;
    logic        fv_r;
    logic        dv_r;
    logic [11:0] img_r;
    logic [10:0] pos_x_r;
    logic [10:0] pos_y_r;

    logic        accept_s;
    logic        pix_en_s;
    logic [10:0] nxt_x_s;
    logic [10:0] nxt_y_s;
    logic        data_hi_unused_s;

    // Strobes outside READ (late FDMA beats after reset or between frames) are dropped here.
    always_comb begin
        accept_s = 1'b0;
        pix_en_s = 1'b0;
        if (state_r == frame_buf_pkg::ST_IDLE) begin
            accept_s = start;
        end else if (state_r == frame_buf_pkg::ST_READ) begin
            pix_en_s = pkg_rd.pkg_rd_en;
        end else begin
            accept_s = 1'b0;
            pix_en_s = 1'b0;
        end
    end

    assign data_hi_unused_s = ^pkg_rd.pkg_rd_data[31:12];

    pix_pos_cnt #(
        .LINE_W (LINE_W),
        .POS_W  (32'd11)
    ) u_pos (
        .clk   (clk_100m),
        .rst   (rst),
        .clr   (accept_s),
        .en    (pix_en_s),
        .pos_x (nxt_x_s),
        .pos_y (nxt_y_s)
    );

    // Frame sequencer with all outward-facing signals registered.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state_r    <= frame_buf_pkg::ST_IDLE;
            pkg_cnt_r  <= 32'd0;
            word_cnt_r <= 32'd0;
            addr_r     <= BASE_ADDR;
            areq_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            len_err_r  <= 1'b0;
            fv_r       <= 1'b0;
            dv_r       <= 1'b0;
            img_r      <= 12'd0;
            pos_x_r    <= 11'd0;
            pos_y_r    <= 11'd0;
        end else begin
            areq_r <= 1'b0;
            done_r <= 1'b0;
            dv_r   <= 1'b0;
            case (state_r)
                frame_buf_pkg::ST_IDLE: begin
                    if (start) begin
                        state_r    <= frame_buf_pkg::ST_REQ;
                        pkg_cnt_r  <= 32'd0;
                        word_cnt_r <= 32'd0;
                        len_err_r  <= 1'b0;
                        busy_r     <= 1'b1;
                        fv_r       <= 1'b1;
                        areq_r     <= 1'b1;
                        addr_r     <= frame_buf_pkg::pkg_addr(BASE_ADDR, 32'd0, STRIDE);
                        pos_x_r    <= 11'd0;
                        pos_y_r    <= 11'd0;
                    end
                end
                frame_buf_pkg::ST_REQ: begin
                    state_r <= frame_buf_pkg::ST_READ;
                end
                frame_buf_pkg::ST_READ: begin
                    if (pkg_rd.pkg_rd_en) begin
                        img_r      <= pkg_rd.pkg_rd_data[11:0];
                        dv_r       <= 1'b1;
                        pos_x_r    <= nxt_x_s;
                        pos_y_r    <= nxt_y_s;
                        word_cnt_r <= word_cnt_r + 32'd1;
                        if (pkg_rd.pkg_rd_last) begin
                            // A short or long package is flagged but the frame still runs out.
                            if (word_cnt_r != WORDS_LAST) begin
                                len_err_r <= 1'b1;
                            end
                            word_cnt_r <= 32'd0;
                            if (pkg_cnt_r == PKG_LAST) begin
                                state_r <= frame_buf_pkg::ST_DONE;
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                                fv_r    <= 1'b0;
                            end else begin
                                state_r   <= frame_buf_pkg::ST_REQ;
                                pkg_cnt_r <= pkg_cnt_r + 32'd1;
                                areq_r    <= 1'b1;
                                addr_r    <= frame_buf_pkg::pkg_addr(BASE_ADDR,
                                                 pkg_cnt_r + 32'd1, STRIDE);
                            end
                        end
                    end
                end
                frame_buf_pkg::ST_DONE: begin
                    state_r <= frame_buf_pkg::ST_IDLE;
                end
                default: begin
                    state_r <= frame_buf_pkg::ST_IDLE;
                end
            endcase
        end
    end

    assign pkg_rd.pkg_rd_addr = addr_r;
    assign pkg_rd.pkg_rd_size = 32'(PKG_WORDS);
    assign pkg_rd.pkg_rd_areq = areq_r;
    assign busy               = busy_r;
    assign done               = done_r;
    assign len_err            = len_err_r;
    assign img                = img_r;
    assign data_valid         = dv_r;
    assign frame_valid        = fv_r;
    assign pos_x              = pos_x_r;
    assign pos_y              = pos_y_r;

endmodule

// File: tb/tb_ddr_frame_reader.sv
// Directed bench for ddr_frame_reader on a 4x8-word frame, 16-pixel lines, base 0x100.
module tb_ddr_frame_reader;

    localparam int unsigned T_BASE   = 32'h100;
    localparam int unsigned T_WORDS  = 32'd8;
    localparam int unsigned T_STRIDE = 32'd4096;
    localparam int unsigned T_NUM    = 32'd4;
    localparam int unsigned T_LINE   = 32'd16;

    logic        clk_100m = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic        busy, done, len_err, data_valid, frame_valid;
    logic [11:0] img;
    logic [10:0] pos_x, pos_y;

    ddr_frame_reader_if bus();

    ddr_frame_reader #(
        .DDR_BASE   (T_BASE),
        .PKG_WORDS  (T_WORDS),
        .PKG_STRIDE (T_STRIDE),
        .PKG_NUM    (T_NUM),
        .LINE_W     (T_LINE)
    ) u_dut (
        .clk_100m    (clk_100m),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .len_err     (len_err),
        .pkg_rd      (bus.master),
        .img         (img),
        .data_valid  (data_valid),
        .frame_valid (frame_valid),
        .pos_x       (pos_x),
        .pos_y       (pos_y)
    );

    always #5 clk_100m = ~clk_100m;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          last_dv_cyc = -2;
    int          fv_rise = 0;
    logic        fv_q = 1'b0;
    logic [11:0] img_q[$];
    logic [10:0] px_q[$];
    logic [10:0] py_q[$];
    logic [31:0] addr_q[$];

    always @(negedge clk_100m) begin
        cyc++;
        if (data_valid) begin
            img_q.push_back(img);
            px_q.push_back(pos_x);
            py_q.push_back(pos_y);
            last_dv_cyc = cyc;
        end
        if (bus.pkg_rd_areq) addr_q.push_back(bus.pkg_rd_addr);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (frame_valid && !fv_q) fv_rise++;
        fv_q = frame_valid;
    end

    task automatic clear_mon();
        img_q.delete();
        px_q.delete();
        py_q.delete();
        addr_q.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        last_dv_cyc = -2;
        fv_rise     = 0;
    endtask

    // FDMA model: wait for areq, then return words whose value is the frame word index.
    task automatic serve_pkg(input bit gaps, input int nwords, input bit give_last, input int start_at);
        int          w;
        int          pidx;
        logic [31:0] a;
        bit          stable;
        w = 0;
        while (bus.pkg_rd_areq !== 1'b1 && w < 40) begin
            @(negedge clk_100m);
            w++;
        end
        check_eq("areq_seen", 64'(w < 40), 64'd1);
        a      = bus.pkg_rd_addr;
        pidx   = int'((a - T_BASE) >> 12);
        stable = 1'b1;
        @(negedge clk_100m);
        for (int k = 0; k < nwords; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) @(negedge clk_100m);
            if (bus.pkg_rd_addr !== a) stable = 1'b0;
            bus.pkg_rd_en   = 1'b1;
            bus.pkg_rd_data = {20'hABCDE, 12'(pidx * int'(T_WORDS) + k)};
            bus.pkg_rd_last = give_last && (k == nwords - 1);
            start           = (k == start_at);
            @(negedge clk_100m);
            bus.pkg_rd_en   = 1'b0;
            bus.pkg_rd_last = 1'b0;
            start           = 1'b0;
        end
        check_eq("addr_stable", 64'(stable), 64'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk_100m);
        start = 1'b1;
        @(negedge clk_100m);
        start = 1'b0;
        check_eq("start_busy", 64'(busy), 64'd1);
        check_eq("start_fv", 64'(frame_valid), 64'd1);
        check_eq("start_areq", 64'(bus.pkg_rd_areq), 64'd1);
        check_eq("start_lenerr", 64'(len_err), 64'd0);
    endtask

    task automatic run_frame(input bit gaps, input int short_pkg, input int start_pkg);
        pulse_start();
        for (int p = 0; p < int'(T_NUM); p++)
            serve_pkg(gaps, (p == short_pkg) ? 7 : 8, 1'b1, (p == start_pkg) ? 3 : -1);
        repeat (3) @(negedge clk_100m);
    endtask

    // Expected stream: img = package*8 + word, pos follows the emitted pixel count.
    task automatic check_frame(input int short_pkg);
        int idx;
        int n_exp;
        n_exp = (short_pkg >= 0) ? 31 : 32;
        check_eq("n_pix", 64'(img_q.size()), 64'(n_exp));
        idx = 0;
        for (int p = 0; p < int'(T_NUM); p++) begin
            for (int k = 0; k < ((p == short_pkg) ? 7 : 8); k++) begin
                if (idx < img_q.size())
                    check_eq($sformatf("pix%0d", idx),
                             64'({img_q[idx], px_q[idx], py_q[idx]}),
                             64'({12'(p * 8 + k), 11'(idx % 16), 11'(idx / 16)}));
                idx++;
            end
        end
        check_eq("n_areq", 64'(addr_q.size()), 64'd4);
        for (int p = 0; p < 4 && p < addr_q.size(); p++)
            check_eq($sformatf("areq_addr%0d", p), 64'(addr_q[p]), 64'(32'h100 + p * 32'h1000));
        check_eq("done_once", 64'(done_cnt), 64'd1);
        check_eq("done_at_last_pix", 64'(done_cyc), 64'(last_dv_cyc));
        check_eq("fv_continuous", 64'(fv_rise), 64'd1);
        check_eq("end_busy", 64'(busy), 64'd0);
        check_eq("end_fv", 64'(frame_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pkg_rd_en   = 1'b0;
        bus.pkg_rd_last = 1'b0;
        bus.pkg_rd_data = 32'd0;
        repeat (3) @(negedge clk_100m);
        rst = 1'b0;
        @(negedge clk_100m);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_lenerr", 64'(len_err), 64'd0);
        check_eq("rst_areq", 64'(bus.pkg_rd_areq), 64'd0);
        check_eq("rst_dv", 64'(data_valid), 64'd0);
        check_eq("rst_fv", 64'(frame_valid), 64'd0);
        check_eq("rst_img", 64'(img), 64'd0);
        check_eq("rst_pos", 64'({pos_x, pos_y}), 64'd0);
        check_eq("rst_addr", 64'(bus.pkg_rd_addr), 64'h100);
        check_eq("rst_size", 64'(bus.pkg_rd_size), 64'd8);

        // Back-to-back strobes.
        clear_mon();
        run_frame(1'b0, -1, -1);
        check_frame(-1);
        check_eq("clean_lenerr", 64'(len_err), 64'd0);

        // Random single-cycle gaps between strobes.
        clear_mon();
        run_frame(1'b1, -1, -1);
        check_frame(-1);

        // Short third package, start re-pulsed during the fourth, strobes in IDLE afterwards.
        clear_mon();
        run_frame(1'b0, 2, 3);
        check_frame(2);
        check_eq("short_lenerr", 64'(len_err), 64'd1);
        for (int k = 0; k < 3; k++) begin
            bus.pkg_rd_en   = 1'b1;
            bus.pkg_rd_last = 1'b1;
            @(negedge clk_100m);
        end
        bus.pkg_rd_en   = 1'b0;
        bus.pkg_rd_last = 1'b0;
        repeat (5) @(negedge clk_100m);
        check_eq("idle_no_pix", 64'(img_q.size()), 64'd31);
        check_eq("idle_no_areq", 64'(addr_q.size()), 64'd4);
        check_eq("idle_done_once", 64'(done_cnt), 64'd1);
        check_eq("lenerr_sticky", 64'(len_err), 64'd1);

        // Next start clears len_err (checked in pulse_start).
        clear_mon();
        run_frame(1'b0, -1, -1);
        check_frame(-1);

        // Reset in the middle of the third package.
        clear_mon();
        pulse_start();
        serve_pkg(1'b0, 8, 1'b1, -1);
        serve_pkg(1'b0, 8, 1'b1, -1);
        serve_pkg(1'b0, 4, 1'b0, -1);
        @(negedge clk_100m);
        check_eq("pre_rst_pos", 64'({pos_x, pos_y}), 64'({11'd3, 11'd1}));
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_fv", 64'(frame_valid), 64'd0);
        check_eq("mid_rst_img", 64'(img), 64'd0);
        check_eq("mid_rst_pos", 64'({pos_x, pos_y}), 64'd0);
        check_eq("mid_rst_addr", 64'(bus.pkg_rd_addr), 64'h100);
        bus.pkg_rd_en = 1'b1;
        @(negedge clk_100m);
        rst = 1'b0;
        repeat (2) @(negedge clk_100m);
        bus.pkg_rd_en = 1'b0;
        @(negedge clk_100m);
        check_eq("rst_pix_cnt", 64'(img_q.size()), 64'd20);
        clear_mon();
        run_frame(1'b0, -1, -1);
        check_frame(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
